// File: rtl/codificador_hamming_serial_if.sv
// codificador_hamming_serial_if: word handshake, error-injection control and codeword/serial outputs
interface codificador_hamming_serial_if;
    logic [3:0] datos_in;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] err_pos;
    logic [6:0] datos_cod;
    logic       cod_valid;
    logic       tx_bit;
    logic       tx_valid;
    logic       tx_last;
    modport master (
        output datos_in, in_valid, err_pos,
        input  in_ready, datos_cod, cod_valid, tx_bit, tx_valid, tx_last
    );
    modport slave (
        input  datos_in, in_valid, err_pos,
        output in_ready, datos_cod, cod_valid, tx_bit, tx_valid, tx_last
    );
endinterface

// File: rtl/codificador_hamming_serial.sv
// codificador_hamming_serial: Hamming(7,4) encoder with optional single-bit error injection and LSB-first serializer
module codificador_hamming_serial #(
    parameter int BIT_CYCLES = 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    codificador_hamming_serial_if.slave        bus
);
    typedef enum logic {IDLE, SHIFT} state_t;
    localparam logic [7:0] LAST_CYC = 8'(BIT_CYCLES - 1);
    state_t     r_state, w_next;
    logic [6:0] r_shift, r_cod;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_cyc_cnt;
    logic       r_cod_valid;
    logic [3:0] w_d;
    logic [6:0] w_code, w_mask;
    logic       w_accept, w_bit_done, w_frame_done;
    always_comb begin
        w_d          = bus.datos_in;
        w_code       = {w_d[3], w_d[2], w_d[1], w_d[1] ^ w_d[2] ^ w_d[3],
                        w_d[0], w_d[0] ^ w_d[2] ^ w_d[3], w_d[0] ^ w_d[1] ^ w_d[3]};
        w_mask       = (bus.err_pos == 3'd0) ? 7'd0 : 7'd1 << (bus.err_pos - 3'd1);
        w_accept     = (r_state == IDLE) && bus.in_valid;
        w_bit_done   = r_cyc_cnt == LAST_CYC;
        w_frame_done = (r_state == SHIFT) && w_bit_done && (r_bit_cnt == 3'd6);
        w_next       = w_accept ? SHIFT : w_frame_done ? IDLE : r_state;
    end
    // bit counter is left at 7 after a frame; the next accept clears it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_shift     <= 7'd0;
            r_cod       <= 7'd0;
            r_bit_cnt   <= 3'd0;
            r_cyc_cnt   <= 8'd0;
            r_cod_valid <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_cod_valid <= w_accept;
            if (w_accept) begin
                r_cod     <= w_code ^ w_mask;
                r_shift   <= w_code ^ w_mask;
                r_bit_cnt <= 3'd0;
                r_cyc_cnt <= 8'd0;
            end else if (r_state == SHIFT) begin
                r_cyc_cnt <= w_bit_done ? 8'd0 : r_cyc_cnt + 8'd1;
                if (w_bit_done) begin
                    r_shift   <= r_shift >> 1;
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end
            end
        end
    end
    assign bus.in_ready  = r_state == IDLE;
    assign bus.tx_valid  = r_state == SHIFT;
    assign bus.tx_bit    = (r_state == SHIFT) && r_shift[0];
    assign bus.tx_last   = (r_state == SHIFT) && (r_bit_cnt == 3'd6);
    assign bus.datos_cod = r_cod;
    assign bus.cod_valid = r_cod_valid;
endmodule

// File: tb/tb_codificador_hamming_serial.sv
// tb_codificador_hamming_serial: two encoders (1 and 3 cycles per bit) driven by scripted/random vectors and
// checked every cycle against a frame-time model, plus literal codeword expectations
module tb_codificador_hamming_serial;
    typedef struct packed {logic rst_n; logic vld; logic [3:0] d; logic [2:0] e;} vec_t;
    typedef struct {int g; logic [3:0] d; logic [2:0] e; logic [6:0] ser; logic [6:0] cod;} frame_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]      rst_n_v, in_valid_v;
    logic [1:0][3:0] datos_v;
    logic [1:0][2:0] err_v;
    logic [1:0]      in_ready_o, cod_valid_o, tx_bit_o, tx_valid_o, tx_last_o;
    logic [1:0][6:0] datos_cod_o;

    for (genvar g = 0; g < 2; g++) begin : gen_dut
        codificador_hamming_serial_if bus ();
        assign bus.datos_in    = datos_v[g];
        assign bus.in_valid    = in_valid_v[g];
        assign bus.err_pos     = err_v[g];
        assign in_ready_o[g]   = bus.in_ready;
        assign cod_valid_o[g]  = bus.cod_valid;
        assign tx_bit_o[g]     = bus.tx_bit;
        assign tx_valid_o[g]   = bus.tx_valid;
        assign tx_last_o[g]    = bus.tx_last;
        assign datos_cod_o[g]  = bus.datos_cod;
        codificador_hamming_serial #(.BIT_CYCLES(g == 0 ? 1 : 3)) dut (
            .clk   (clk),
            .rst_n (rst_n_v[g]),
            .bus   (bus.slave)
        );
    end

    int         checks = 0;
    int         failures = 0;
    vec_t       scr [2][$];
    vec_t       cur [2];
    frame_t     frames [$];
    bit         m_busy [2];
    bit         m_cv [2];
    int         m_t [2];
    logic [6:0] m_cod [2], m_dc [2], obs_ser [2], obs_cod [2];
    logic [3:0] m_d [2];
    logic [2:0] m_e [2];

    localparam logic [3:0] LD [6] = '{4'h0, 4'hB, 4'h1, 4'h8, 4'hF, 4'hB};
    localparam logic [2:0] LE [6] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd3};
    localparam logic [6:0] LC [6] = '{7'h00, 7'h55, 7'h07, 7'h4B, 7'h7F, 7'h51};

    function automatic int bc(input int g);
        return g == 0 ? 1 : 3;
    endfunction

    // classic position view: parity at positions 1,2,4 covers every position sharing that bit
    function automatic logic [6:0] enc(input logic [3:0] d, input logic [2:0] e);
        logic [6:0] w;
        int k;
        w = '0;
        k = 0;
        for (int p = 1; p <= 7; p++)
            if ((p & (p - 1)) != 0) begin
                w[p - 1] = d[k];
                k++;
            end
        for (int p = 1; p <= 4; p = p * 2)
            for (int q = 1; q <= 7; q++)
                if ((q & p) != 0 && q != p) w[p - 1] = w[p - 1] ^ w[q - 1];
        if (e != 3'd0) w[int'(e) - 1] = ~w[int'(e) - 1];
        return w;
    endfunction

    function automatic logic [3:0] dec(input logic [6:0] c);
        logic [6:0] w;
        logic [3:0] d;
        int s, k;
        w = c;
        s = 0;
        k = 0;
        d = '0;
        for (int q = 1; q <= 7; q++) if (w[q - 1]) s = s ^ q;
        if (s != 0) w[s - 1] = ~w[s - 1];
        for (int p = 1; p <= 7; p++)
            if ((p & (p - 1)) != 0) begin
                d[k] = w[p - 1];
                k++;
            end
        return d;
    endfunction

    task automatic chk(input int g, input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d t=%0t actual=%0h required=%0h", name, g, $time, act, exp);
        end
    endtask

    task automatic add(input int g, input int n, input logic r, input logic v, input logic [3:0] d, input logic [2:0] e);
        vec_t x;
        x = '{rst_n: r, vld: v, d: d, e: e};
        repeat (n) scr[g].push_back(x);
    endtask

    task automatic build(input int g);
        int l;
        l = 7 * bc(g);
        add(g, 2, 1'b0, 1'b1, 4'hB, 3'd0);
        add(g, 1, 1'b1, 1'b1, 4'hB, 3'd0);
        add(g, l + 2, 1'b1, 1'b0, 4'h0, 3'd0);
        for (int d = 0; d < 16; d++) begin
            add(g, 1, 1'b1, 1'b1, 4'(d), 3'd0);
            add(g, l + 1, 1'b1, 1'b0, 4'h0, 3'd0);
        end
        add(g, 1, 1'b1, 1'b1, 4'hB, 3'd3);
        add(g, l + 2, 1'b1, 1'b0, 4'h0, 3'd0);
        add(g, 2, 1'b1, 1'b1, 4'h6, 3'd0);
        add(g, 2 * l + 4, 1'b1, 1'b1, 4'hD, 3'd0);
        add(g, l + 2, 1'b1, 1'b0, 4'h0, 3'd0);
        add(g, 1, 1'b1, 1'b1, 4'h8, 3'd0);
        add(g, 3 * bc(g), 1'b1, 1'b0, 4'h0, 3'd0);
        add(g, 1, 1'b0, 1'b0, 4'h0, 3'd0);
        add(g, l + 2, 1'b1, 1'b0, 4'h0, 3'd0);
        repeat (400)
            add(g, 1, $urandom_range(0, 39) != 0, $urandom_range(0, 2) == 0,
                4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
        add(g, l + 2, 1'b1, 1'b0, 4'h0, 3'd0);
    endtask

    task automatic fetch(input int g, input int i);
        vec_t idle;
        idle = '{rst_n: 1'b1, vld: 1'b0, d: 4'h0, e: 3'd0};
        cur[g] = (i < scr[g].size()) ? scr[g][i] : idle;
        rst_n_v[g]    = cur[g].rst_n;
        in_valid_v[g] = cur[g].vld;
        datos_v[g]    = cur[g].d;
        err_v[g]      = cur[g].e;
    endtask

    task automatic step(input int g);
        if (!cur[g].rst_n) begin
            m_busy[g] = 1'b0;
            m_cv[g]   = 1'b0;
            m_dc[g]   = 7'd0;
            m_t[g]    = 0;
        end else if (!m_busy[g]) begin
            m_cv[g] = cur[g].vld;
            if (cur[g].vld) begin
                m_cod[g]  = enc(cur[g].d, cur[g].e);
                m_dc[g]   = m_cod[g];
                m_d[g]    = cur[g].d;
                m_e[g]    = cur[g].e;
                m_busy[g] = 1'b1;
                m_t[g]    = 0;
            end
        end else begin
            m_cv[g] = 1'b0;
            m_t[g]++;
            if (m_t[g] == 7 * bc(g)) m_busy[g] = 1'b0;
        end
    endtask

    task automatic compare(input int g);
        int n;
        frame_t f;
        n = m_t[g] / bc(g);
        chk(g, "in_ready", 7'(in_ready_o[g]), 7'(!m_busy[g]));
        chk(g, "tx_valid", 7'(tx_valid_o[g]), 7'(m_busy[g]));
        chk(g, "tx_bit", 7'(tx_bit_o[g]), m_busy[g] ? 7'(m_cod[g][n]) : 7'd0);
        chk(g, "tx_last", 7'(tx_last_o[g]), 7'(m_busy[g] && n == 6));
        chk(g, "cod_valid", 7'(cod_valid_o[g]), 7'(m_cv[g]));
        chk(g, "datos_cod", datos_cod_o[g], m_dc[g]);
        if (cod_valid_o[g]) obs_cod[g] = datos_cod_o[g];
        if (m_busy[g] && m_t[g] % bc(g) == 0) obs_ser[g][n] = tx_bit_o[g];
        if (m_busy[g] && m_t[g] == 7 * bc(g) - 1) begin
            f.g = g;
            f.d = m_d[g];
            f.e = m_e[g];
            f.ser = obs_ser[g];
            f.cod = obs_cod[g];
            frames.push_back(f);
        end
    endtask

    initial begin
        int n;
        bit found;
        for (int g = 0; g < 2; g++) begin
            build(g);
            fetch(g, 0);
        end
        n = scr[0].size() > scr[1].size() ? scr[0].size() : scr[1].size();
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            for (int g = 0; g < 2; g++) step(g);
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                compare(g);
                fetch(g, c + 1);
            end
        end
        for (int i = 0; i < 6; i++) chk(-1, "model_enc", enc(LD[i], LE[i]), LC[i]);
        for (int g = 0; g < 2; g++)
            for (int i = 0; i < 6; i++) begin
                found = 1'b0;
                foreach (frames[j])
                    if (!found && frames[j].g == g && frames[j].d == LD[i] && frames[j].e == LE[i]) begin
                        found = 1'b1;
                        chk(g, "frame_serial", frames[j].ser, LC[i]);
                        chk(g, "frame_cod", frames[j].cod, LC[i]);
                        chk(g, "frame_decoded", 7'(dec(frames[j].ser)), 7'(LD[i]));
                    end
                chk(g, "frame_seen", 7'(found), 7'd1);
            end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
